bus_grant_controller: RTL and testbench
=======================================

# bus_grant_controller

Sequencing arbiter for the MCU internal bus. It shares the single SRAM slave port between up to four masters, for example the SPI memory initializer and the AFTAB CPU. A grant is held for a whole transaction, ending on slave ready, on master abort, or on timeout. A one-cycle turnaround follows every release, and a per-transaction watchdog protects the bus against a stuck slave. It sits beside the bus mux and drives that mux's grant lines, replacing the static SPI_request-based selection.

## Interface
- NUM_MASTERS, 2: number of requesters, legal range 2..4.
- PRIORITY_MODE, 0: 0 = fixed priority (master 0 highest); 1 = round-robin.
- TIMEOUT_CYCLES, 255: maximum cycles in GRANTED without slave_ready; legal range 1..255.
- CNT_W, 8: watchdog counter width; must hold TIMEOUT_CYCLES.
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset. Asserting it clears all state immediately; release is synchronous to clk.
- req  in  NUM_MASTERS  per-master request (master READ | WRITE); must stay high until that master sees ready.
- lock  in  NUM_MASTERS  per-master burst lock; sampled on completion and keeps the grant for the next transfer.
- slave_ready  in  1  transfer-complete strobe from the slave.
- grant  out  NUM_MASTERS  one-hot grant, registered; all zero when no owner.
- grant_valid  out  1  OR of grant.
- cur_master  out  2  index of the current or last owner.
- timeout_err  out  1  one-cycle pulse on watchdog expiry.
- err_master  out  2  index of the master that timed out; held until the next timeout.

## Operation
- States: IDLE, GRANTED, RELEASE. State, grant, cur_master, the round-robin pointer and the counter are all registered.
- Winner select:
  - Fixed mode: the lowest requesting index wins.
  - Round-robin mode: search starts at the pointer, ascending and wrapping at NUM_MASTERS-1 → 0.
  - The pointer updates to (winner+1) mod NUM_MASTERS whenever a grant is issued.
- IDLE: if req≠0, latch winner, grant←onehot(winner), cur_master←winner, counter←0, go to GRANTED. Otherwise stay; grant stays 0.
- GRANTED, owner g, priority order of events:
  1. req[g]=0 (abort): go to RELEASE. No error.
  2. slave_ready=1, lock[g]=1 and req[g]=1: stay GRANTED, counter←0. The burst continues and no other master can pre-empt.
  3. slave_ready=1 otherwise: go to RELEASE.
  4. counter==TIMEOUT_CYCLES-1: timeout_err←1 for one cycle, err_master←g, go to RELEASE.
  5. Otherwise: counter←counter+1.
- RELEASE: grant←0 for exactly one cycle (bus turnaround). Arbitration runs in the same cycle. If req≠0, go to GRANTED with the new winner; otherwise go to IDLE.
- A master that just released may win again straight out of RELEASE:
  - Fixed mode: it wins if it is still the highest requester.
  - Round-robin mode: the pointer has already moved past it.
- Requests from non-owners while in GRANTED are ignored and never observed by the slave.
- Counter saturates and never wraps, because expiry forces RELEASE.
- NUM_MASTERS=2: the upper index bit is 0 and unused req/lock bits do not exist.

## Timing
- Reset values: grant=0, grant_valid=0, cur_master=0, timeout_err=0, err_master=0, state=IDLE, pointer=0, counter=0.
- Grant latency: req rising, sampled at edge n in IDLE, gives grant visible after edge n. Latency is 1 cycle.
- Release: slave_ready sampled at edge k gives grant=0 during cycle k+1. The next grant is visible after edge k+1, so the minimum gap between owners is 1 idle bus cycle.
- Locked burst: consecutive slave_ready strobes keep grant high continuously, with no gap.
- Timeout: grant issued at edge n with no ready gives timeout_err high during the cycle after edge n+TIMEOUT_CYCLES, and grant low in that same cycle.
- Event coincidences:
  - slave_ready together with counter expiry: ready wins and no error is raised.
  - Abort (req[g]=0) together with slave_ready: treated as a completion, not locked.
- Reset mid-transaction: grant drops asynchronously. No timeout pulse is generated, and after release arbitration restarts from pointer 0.

## Structure
- Shared header/package (bus_pkg): state encodings (ST_IDLE=2'd0, ST_GRANTED=2'd1, ST_RELEASE=2'd2), ARB_FIXED=0, ARB_RR=1, MAX_MASTERS=4.
- One combinational sub-module, rr_priority_picker:
  - Inputs: req, pointer, mode.
  - Outputs: winner index, any_req.
- The FSM, counter and output registers stay in bus_grant_controller.

## Test plan
- Reset: hold rst=0 with req=2'b11, then release. All outputs stay 0 until the first edge after release. Fixed mode then grants 2'b01 one cycle later.
- Fixed contention: req=2'b11 continuously, slave_ready every 3rd cycle. Master 0 holds every grant, with a one-cycle grant=0 gap after each ready.
- Round-robin: PRIORITY_MODE=1, NUM_MASTERS=3, req=3'b111, ready 1 cycle after each grant. Grants go 001, 010, 100, 001, each separated by one zero cycle.
- Lock burst: master 1 lock=1 for 4 readies, with master 0 also requesting. Grant stays 2'b10 with no gap through all 4. The lock drops on the 4th ready, and master 0 is granted after one RELEASE cycle.
- Timeout: TIMEOUT_CYCLES=5, master 1 granted, slave_ready held 0. timeout_err pulses for exactly 1 cycle, 5 cycles after the grant edge, with err_master=1 and grant=0 in that cycle.
- Abort and async reset: owner drops req mid-transfer, giving RELEASE and no error. Asserting rst while grant≠0 clears grant within the same cycle, with no edge needed.

Source files
------------

// File: rtl/bus_grant_controller_pkg.sv
// Shared definitions for the bus grant controller: FSM encodings,
// arbitration mode selectors and sizing limits.
package bus_pkg;

    localparam int MAX_MASTERS = 4;
    localparam int IDX_W       = 2;

    localparam logic ARB_FIXED = 1'b0;
    localparam logic ARB_RR    = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_RELEASE = 2'd2
    } bus_state_e;

endpackage

// File: rtl/bus_grant_controller_picker.sv
// Combinational winner selection. Fixed mode scans upward from index 0;
// round-robin mode scans upward from the pointer and wraps at NUM_MASTERS-1.
module rr_priority_picker
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS = 2
) (
    input  logic [MAX_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       pointer,
    input  logic                   mode,
    output logic [IDX_W-1:0]       winner,
    output logic                   any_req
);

    logic [IDX_W-1:0] start_s;
    logic [2:0]       cand_s;

    // First requesting index found from the start position wins.
    always_comb begin
        winner  = {IDX_W{1'b0}};
        any_req = 1'b0;
        cand_s  = 3'd0;
        if (mode == ARB_RR) begin
            start_s = pointer;
        end else begin
            start_s = {IDX_W{1'b0}};
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand_s = {1'b0, start_s} + 3'(i);
            if (cand_s >= 3'(NUM_MASTERS)) begin
                cand_s = cand_s - 3'(NUM_MASTERS);
            end else begin
                cand_s = cand_s;
            end
            if (!any_req && req[cand_s[IDX_W-1:0]]) begin
                winner  = cand_s[IDX_W-1:0];
                any_req = 1'b1;
            end else begin
                winner  = winner;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/bus_grant_controller.sv
// Transaction-level arbiter for the shared SRAM slave port. Holds a grant
// until ready/abort/timeout, inserts one turnaround cycle after every release,
// and keeps a per-transaction watchdog against a stuck slave.
module bus_grant_controller
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int PRIORITY_MODE  = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] lock,
    input  logic                   slave_ready,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   grant_valid,
    output logic [1:0]             cur_master,
    output logic                   timeout_err,
    output logic [1:0]             err_master
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic             MODE     = (PRIORITY_MODE == 1) ? ARB_RR : ARB_FIXED;

    bus_state_e             state_r, state_next_s;
    logic [CNT_W-1:0]       cnt_r, cnt_next_s;
    logic [IDX_W-1:0]       ptr_r, ptr_next_s;
    logic [IDX_W-1:0]       cur_master_r, cur_master_next_s;
    logic [NUM_MASTERS-1:0] grant_r, grant_next_s;
    logic                   grant_valid_r;
    logic                   timeout_err_r, timeout_err_next_s;
    logic [IDX_W-1:0]       err_master_r, err_master_next_s;

    logic [MAX_MASTERS-1:0] req_ext_s, lock_ext_s;
    logic [IDX_W-1:0]       winner_s;
    logic                   any_req_s;
    logic                   owner_req_s, owner_lock_s;
    logic                   issue_s, expire_s;

    // Widen request/lock to the maximum master count; absent masters read as 0.
    always_comb begin
        req_ext_s                    = {MAX_MASTERS{1'b0}};
        lock_ext_s                   = {MAX_MASTERS{1'b0}};
        req_ext_s[NUM_MASTERS-1:0]  = req;
        lock_ext_s[NUM_MASTERS-1:0] = lock;
        owner_req_s                  = req_ext_s[cur_master_r];
        owner_lock_s                 = lock_ext_s[cur_master_r];
    end

    rr_priority_picker #(
        .NUM_MASTERS(NUM_MASTERS)
    ) u_picker (
        .req    (req_ext_s),
        .pointer(ptr_r),
        .mode   (MODE),
        .winner (winner_s),
        .any_req(any_req_s)
    );

    // State, watchdog, pointer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            ptr_r         <= {IDX_W{1'b0}};
            cur_master_r  <= {IDX_W{1'b0}};
            grant_r       <= {NUM_MASTERS{1'b0}};
            grant_valid_r <= 1'b0;
            timeout_err_r <= 1'b0;
            err_master_r  <= {IDX_W{1'b0}};
        end else begin
            state_r       <= state_next_s;
            cnt_r         <= cnt_next_s;
            ptr_r         <= ptr_next_s;
            cur_master_r  <= cur_master_next_s;
            grant_r       <= grant_next_s;
            grant_valid_r <= |grant_next_s;
            timeout_err_r <= timeout_err_next_s;
            err_master_r  <= err_master_next_s;
        end
    end

    // Next-state logic: arbitration out of IDLE/RELEASE, event priority in GRANTED.
    always_comb begin
        state_next_s      = state_r;
        cnt_next_s        = cnt_r;
        ptr_next_s        = ptr_r;
        cur_master_next_s = cur_master_r;
        issue_s           = 1'b0;
        expire_s          = 1'b0;
        case (state_r)
            ST_IDLE, ST_RELEASE: begin
                if (any_req_s) begin
                    state_next_s      = ST_GRANTED;
                    issue_s           = 1'b1;
                    cur_master_next_s = winner_s;
                    cnt_next_s        = {CNT_W{1'b0}};
                    if (winner_s == IDX_W'(NUM_MASTERS - 1)) begin
                        ptr_next_s = {IDX_W{1'b0}};
                    end else begin
                        ptr_next_s = winner_s + 2'd1;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANTED: begin
                if (!owner_req_s) begin
                    state_next_s = ST_RELEASE;
                end else if (slave_ready && owner_lock_s) begin
                    cnt_next_s = {CNT_W{1'b0}};
                end else if (slave_ready) begin
                    state_next_s = ST_RELEASE;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s     = 1'b1;
                    state_next_s = ST_RELEASE;
                end else begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        grant_next_s       = {NUM_MASTERS{1'b0}};
        timeout_err_next_s = expire_s;
        err_master_next_s  = err_master_r;
        if (issue_s) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                grant_next_s[i] = (winner_s == IDX_W'(i));
            end
        end else if (state_next_s == ST_GRANTED) begin
            grant_next_s = grant_r;
        end else begin
            grant_next_s = {NUM_MASTERS{1'b0}};
        end
        if (expire_s) begin
            err_master_next_s = cur_master_r;
        end else begin
            err_master_next_s = err_master_r;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign cur_master  = cur_master_r;
    assign timeout_err = timeout_err_r;
    assign err_master  = err_master_r;

endmodule

// File: tb/tb_bus_grant_controller.sv
// Directed bench for bus_grant_controller: fixed-priority, round-robin and
// short-watchdog instances driven in one linear sequence.
module tb_bus_grant_controller;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Fixed priority, two masters, default watchdog
    logic [1:0] req_a, lock_a, grant_a, cm_a, em_a;
    logic       rdy_a, gv_a, te_a;
    // Round-robin, three masters
    logic [2:0] req_b, lock_b, grant_b;
    logic [1:0] cm_b, em_b;
    logic       rdy_b, gv_b, te_b;
    // Fixed priority, two masters, watchdog of 5
    logic [1:0] req_c, lock_c, grant_c, cm_c, em_c;
    logic       rdy_c, gv_c, te_c;

    bus_grant_controller #(.NUM_MASTERS(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(255), .CNT_W(8)) u_fix (
        .clk(clk), .rst(rst), .req(req_a), .lock(lock_a), .slave_ready(rdy_a),
        .grant(grant_a), .grant_valid(gv_a), .cur_master(cm_a),
        .timeout_err(te_a), .err_master(em_a));

    bus_grant_controller #(.NUM_MASTERS(3), .PRIORITY_MODE(1), .TIMEOUT_CYCLES(255), .CNT_W(8)) u_rr (
        .clk(clk), .rst(rst), .req(req_b), .lock(lock_b), .slave_ready(rdy_b),
        .grant(grant_b), .grant_valid(gv_b), .cur_master(cm_b),
        .timeout_err(te_b), .err_master(em_b));

    bus_grant_controller #(.NUM_MASTERS(2), .PRIORITY_MODE(0), .TIMEOUT_CYCLES(5), .CNT_W(8)) u_to (
        .clk(clk), .rst(rst), .req(req_c), .lock(lock_c), .slave_ready(rdy_c),
        .grant(grant_c), .grant_valid(gv_c), .cur_master(cm_c),
        .timeout_err(te_c), .err_master(em_c));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b0;
        req_a  = 2'b11; lock_a = 2'b00; rdy_a = 1'b0;
        req_b  = 3'b000; lock_b = 3'b000; rdy_b = 1'b0;
        req_c  = 2'b00; lock_c = 2'b00; rdy_c = 1'b0;

        // ---------------- reset with requests pending ----------------
        #3;
        check("rst_grant", 32'(grant_a), 32'h0);
        check("rst_gv", 32'(gv_a), 32'h0);
        check("rst_cm", 32'(cm_a), 32'h0);
        check("rst_te", 32'(te_a), 32'h0);
        check("rst_em", 32'(em_a), 32'h0);
        step();
        step();
        check("rst_hold_grant", 32'(grant_a), 32'h0);
        rst = 1'b1;
        #1;
        check("rel_no_edge_grant", 32'(grant_a), 32'h0);
        step();
        check("first_grant", 32'(grant_a), 32'h1);
        check("first_gv", 32'(gv_a), 32'h1);
        check("first_cm", 32'(cm_a), 32'h0);

        // ---------------- fixed contention, ready every third cycle ----------------
        for (int r = 0; r < 2; r++) begin
            rdy_a = 1'b0;
            step();
            check("fix_hold", 32'(grant_a), 32'h1);
            rdy_a = 1'b1;
            step();
            check("fix_gap", 32'(grant_a), 32'h0);
            check("fix_gap_gv", 32'(gv_a), 32'h0);
            rdy_a = 1'b0;
            step();
            check("fix_regrant", 32'(grant_a), 32'h1);
            check("fix_regrant_cm", 32'(cm_a), 32'h0);
        end

        // ---------------- abort by master 0, master 1 takes over ----------------
        req_a = 2'b10;
        step();
        check("abort_release", 32'(grant_a), 32'h0);
        check("abort_no_err", 32'(te_a), 32'h0);
        step();
        check("m1_grant", 32'(grant_a), 32'h2);
        check("m1_cm", 32'(cm_a), 32'h1);

        // ---------------- locked burst with master 0 contending ----------------
        req_a  = 2'b11;
        lock_a = 2'b10;
        rdy_a  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("lock_burst", 32'(grant_a), 32'h2);
            check("lock_burst_gv", 32'(gv_a), 32'h1);
        end
        lock_a = 2'b00;
        step();
        check("lock_end_gap", 32'(grant_a), 32'h0);
        rdy_a = 1'b0;
        req_a = 2'b01;
        step();
        check("after_lock_grant", 32'(grant_a), 32'h1);
        check("after_lock_cm", 32'(cm_a), 32'h0);

        // ---------------- abort to idle, then async reset mid-transfer ----------------
        req_a = 2'b00;
        step();
        check("abort_idle_grant", 32'(grant_a), 32'h0);
        check("abort_idle_te", 32'(te_a), 32'h0);
        step();
        check("idle_grant", 32'(grant_a), 32'h0);
        req_a = 2'b10;
        step();
        check("pre_rst_grant", 32'(grant_a), 32'h2);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_grant", 32'(grant_a), 32'h0);
        check("async_rst_gv", 32'(gv_a), 32'h0);
        check("async_rst_cm", 32'(cm_a), 32'h0);
        check("async_rst_te", 32'(te_a), 32'h0);
        step();
        rst   = 1'b1;
        req_a = 2'b00;

        // ---------------- round-robin, three masters ----------------
        req_b = 3'b111;
        step();
        check("rr_g0", 32'(grant_b), 32'h1);
        rdy_b = 1'b1;
        step();
        check("rr_gap0", 32'(grant_b), 32'h0);
        rdy_b = 1'b0;
        step();
        check("rr_g1", 32'(grant_b), 32'h2);
        check("rr_g1_cm", 32'(cm_b), 32'h1);
        rdy_b = 1'b1;
        step();
        check("rr_gap1", 32'(grant_b), 32'h0);
        rdy_b = 1'b0;
        step();
        check("rr_g2", 32'(grant_b), 32'h4);
        check("rr_g2_cm", 32'(cm_b), 32'h2);
        rdy_b = 1'b1;
        step();
        check("rr_gap2", 32'(grant_b), 32'h0);
        rdy_b = 1'b0;
        step();
        check("rr_wrap", 32'(grant_b), 32'h1);
        rdy_b = 1'b1;
        step();
        check("rr_gap3", 32'(grant_b), 32'h0);
        rdy_b = 1'b0;
        step();
        check("rr_g1_again", 32'(grant_b), 32'h2);
        // reset while pointer sits at 2: arbitration must restart from 0
        #2;
        rst = 1'b0;
        #1;
        check("rr_async_rst", 32'(grant_b), 32'h0);
        step();
        rst = 1'b1;
        step();
        check("rr_ptr_reset", 32'(grant_b), 32'h1);
        req_b = 3'b000;

        // ---------------- watchdog expiry ----------------
        req_c = 2'b10;
        step();
        check("to_grant", 32'(grant_c), 32'h2);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("to_wait_grant", 32'(grant_c), 32'h2);
            check("to_wait_te", 32'(te_c), 32'h0);
        end
        step();
        check("to_pulse", 32'(te_c), 32'h1);
        check("to_em", 32'(em_c), 32'h1);
        check("to_grant_low", 32'(grant_c), 32'h0);
        step();
        check("to_pulse_end", 32'(te_c), 32'h0);
        check("to_em_held", 32'(em_c), 32'h1);
        check("to_regrant", 32'(grant_c), 32'h2);
        // ready coinciding with expiry: completion, no error
        for (int k = 1; k <= 4; k++) begin
            step();
        end
        check("coinc_pre_grant", 32'(grant_c), 32'h2);
        rdy_c = 1'b1;
        step();
        check("coinc_release", 32'(grant_c), 32'h0);
        check("coinc_no_err", 32'(te_c), 32'h0);
        rdy_c = 1'b0;
        req_c = 2'b00;
        step();
        check("coinc_idle", 32'(grant_c), 32'h0);
        check("coinc_em_held", 32'(em_c), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
